mod_rr_arbiter: RTL and testbench
=================================

MOD_RR_ARBITER -- requirements
Module: mod_rr_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 NUM_CLIENTS, 2, number of cache clients; legal range 2..8.
REQ-002 LINE_WIDTH, 512, cache line width in bits.
REQ-003 BEAT_WIDTH, 64, system bus data width in bits; LINE_WIDTH SHALL be a multiple of BEAT_WIDTH; BEATS = LINE_WIDTH/BEAT_WIDTH.
REQ-004 TAG_WIDTH, 13, request/response tag width; tag bit 0 = 1 read, 0 write.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cl_reqcyc  in  NUM_CLIENTS  per-client request valid.
REQ-008 cl_req  in  NUM_CLIENTS*BEAT_WIDTH  per-client line address.
REQ-009 cl_reqtag  in  NUM_CLIENTS*TAG_WIDTH  per-client request tag.
REQ-010 cl_reqdata  in  NUM_CLIENTS*LINE_WIDTH  per-client write line; beat k = bits [k*BEAT_WIDTH +: BEAT_WIDTH].
REQ-011 cl_reqack  out  NUM_CLIENTS  one-hot, one-cycle grant pulse.
REQ-012 cl_respcyc  out  NUM_CLIENTS  one-hot, one-cycle completion pulse.
REQ-013 cl_resp  out  LINE_WIDTH  assembled read line, valid with cl_respcyc.
REQ-014 cl_resptag  out  TAG_WIDTH  response tag, valid with cl_respcyc.
REQ-015 bus_reqcyc / bus_req / bus_reqtag  out  1 / BEAT_WIDTH / TAG_WIDTH  system bus request beat.
REQ-016 bus_reqack  in  1  system bus accepts current request beat.
REQ-017 bus_respcyc / bus_resp / bus_resptag  in  1 / BEAT_WIDTH / TAG_WIDTH  system bus response beat.
REQ-018 bus_respack  out  1  combinationally equal to bus_respcyc.

Function
REQ-019 States: IDLE, ADDR, RD_DATA, WR_DATA, DONE.
REQ-020 IDLE: with any cl_reqcyc set, SHALL grant exactly one client by round-robin starting from the client after the last granted one; pulse its cl_reqack; latch its address, tag and write line; enter ADDR.
REQ-021 ADDR: bus_reqcyc=1 with latched address/tag; on bus_reqack -> RD_DATA if tag bit 0 = 1, else WR_DATA with bus_req holding beat 0.
REQ-022 WR_DATA: bus_reqcyc=1, bus_req = latched beat index; each bus_reqack advances index; on acceptance of beat BEATS-1 -> DONE.
REQ-023 RD_DATA: bus_reqcyc=0; each bus_respcyc stores bus_resp into beat index and increments it; beat BEATS-1 latches bus_resptag -> DONE.
REQ-024 DONE: pulse granted client's cl_respcyc for one cycle with complete cl_resp (all BEATS beats, including the last) and cl_resptag; -> IDLE; beat index cleared.
REQ-025 Beat index SHALL be ceil(log2(BEATS)) bits wide and count exactly BEATS beats; no off-by-one.
REQ-026 Round-robin pointer SHALL update only on grant; wraps NUM_CLIENTS-1 -> 0.
REQ-027 Requests arriving outside IDLE SHALL wait; cl_reqcyc changes of the granted client after grant SHALL be ignored.
REQ-028 bus_respcyc outside RD_DATA SHALL be acknowledged and discarded; simulation SHALL flag it as an error.
REQ-029 Minimum transaction latency: grant to cl_respcyc = 2 + BEATS cycles with zero-wait bus.

Reset
REQ-030 On reset: state IDLE, pointer 0 (client 0 highest priority), beat index 0, cl_reqack=0, cl_respcyc=0, bus_reqcyc=0, cl_resp/cl_resptag/bus_req/bus_reqtag=0.
REQ-031 Reset mid-transaction SHALL abandon it with no cl_respcyc issued; next cycle after reset release behaves as IDLE.

Verification
REQ-032 Read, client 0, addr 0x1000, tag 0x0001, bus returns beats 0..7 = 0x00..07 repeated -> one cl_respcyc[0], cl_resp beat k = k, cl_resptag = bus_resptag.
REQ-033 Write, client 1, tag 0x0000, line beats 0xA0..0xA7, bus_reqack every cycle -> address then 8 data beats in order, then cl_respcyc[1].
REQ-034 Clients 0 and 1 request same cycle repeatedly -> grants alternate 0,1,0,1.
REQ-035 bus_reqack held low 5 cycles during WR_DATA -> bus_req stable, no beat skipped or duplicated.
REQ-036 Reset asserted after 3 read beats -> no cl_respcyc, all outputs at reset values; subsequent read completes correctly.
REQ-037 NUM_CLIENTS=4, BEAT_WIDTH=128 -> 4-beat lines, round-robin over 4 clients verified.

Source files
------------

// File: rtl/mod_rr_arbiter.sv
// mod_rr_arbiter
// Round-robin arbiter that lets NUM_CLIENTS cache clients share one system bus.
// A granted client's request goes out as one address beat. A write then sends
// BEATS data beats. A read instead collects BEATS response beats into a full
// line, which is returned to the client with a single completion pulse.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   cl_reqcyc/cl_req/cl_reqtag      per-client request valid, line address, tag
//   cl_reqdata                      per-client write line (beat k at k*BEAT_WIDTH)
//   cl_reqack                       one-hot grant pulse
//   cl_respcyc/cl_resp/cl_resptag   one-hot completion pulse, read line, tag
//   bus_reqcyc/bus_req/bus_reqtag   system bus request beat
//   bus_reqack                      bus accepts current request beat
//   bus_respcyc/bus_resp/bus_resptag system bus response beat
//   bus_respack                     equal to bus_respcyc (always accepted)
//
// state   | meaning
// IDLE    | waiting for a request, round-robin grant
// ADDR    | address beat on the bus
// RD_DATA | collecting response beats into the read line
// WR_DATA | sending write-line beats
// DONE    | completion pulse to the granted client
module mod_rr_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int LINE_WIDTH  = 512,
    parameter int BEAT_WIDTH  = 64,
    parameter int TAG_WIDTH   = 13
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            cl_reqcyc,
    input  logic [NUM_CLIENTS*BEAT_WIDTH-1:0] cl_req,
    input  logic [NUM_CLIENTS*TAG_WIDTH-1:0]  cl_reqtag,
    input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] cl_reqdata,
    output logic [NUM_CLIENTS-1:0]            cl_reqack,
    output logic [NUM_CLIENTS-1:0]            cl_respcyc,
    output logic [LINE_WIDTH-1:0]             cl_resp,
    output logic [TAG_WIDTH-1:0]              cl_resptag,
    output logic                              bus_reqcyc,
    output logic [BEAT_WIDTH-1:0]             bus_req,
    output logic [TAG_WIDTH-1:0]              bus_reqtag,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    input  logic [BEAT_WIDTH-1:0]             bus_resp,
    input  logic [TAG_WIDTH-1:0]              bus_resptag,
    output logic                              bus_respack
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = $clog2(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [PTR_W-1:0] LAST_CL  = PTR_W'(NUM_CLIENTS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, RD_DATA, WR_DATA, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       owner_q;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       cand;
    logic                   gnt_found;
    logic [IDX_W-1:0]       idx_q;
    logic [BEAT_WIDTH-1:0]  addr_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [LINE_WIDTH-1:0]  wr_line_q;
    logic [LINE_WIDTH-1:0]  rd_line_q;
    logic [TAG_WIDTH-1:0]   resp_tag_q;

    // Search starts at ptr_q, the client after the last one granted.
    always_comb begin
        gnt_idx   = ptr_q;
        gnt_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_CLIENTS);
            if (!gnt_found && cl_reqcyc[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cl_reqack  = '0;
        cl_respcyc = '0;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        // While reset is held, nothing is granted and the bus request stays quiet.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        cl_reqack[gnt_idx] = 1'b1;
                        state_d            = ADDR;
                    end
                end
                ADDR: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = addr_q;
                    bus_reqtag = tag_q;
                    if (bus_reqack) begin
                        state_d = tag_q[0] ? RD_DATA : WR_DATA;
                    end
                end
                WR_DATA: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = wr_line_q[idx_q*BEAT_WIDTH +: BEAT_WIDTH];
                    bus_reqtag = tag_q;
                    if (bus_reqack && (idx_q == LAST_IDX)) begin
                        state_d = DONE;
                    end
                end
                RD_DATA: begin
                    if (bus_respcyc && (idx_q == LAST_IDX)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    cl_respcyc[owner_q] = 1'b1;
                    state_d             = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            wr_line_q  <= '0;
            rd_line_q  <= '0;
            resp_tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        owner_q   <= gnt_idx;
                        ptr_q     <= (gnt_idx == LAST_CL) ? '0 : gnt_idx + 1'b1;
                        addr_q    <= cl_req[gnt_idx*BEAT_WIDTH +: BEAT_WIDTH];
                        tag_q     <= cl_reqtag[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
                        wr_line_q <= cl_reqdata[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
                        idx_q     <= '0;
                    end
                end
                WR_DATA: begin
                    if (bus_reqack) begin
                        if (idx_q == LAST_IDX) begin
                            resp_tag_q <= tag_q;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    if (bus_respcyc) begin
                        rd_line_q[idx_q*BEAT_WIDTH +: BEAT_WIDTH] <= bus_resp;
                        if (idx_q == LAST_IDX) begin
                            resp_tag_q <= bus_resptag;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: idx_q <= '0;
                default: ;
            endcase
        end
    end

    assign cl_resp     = rd_line_q;
    assign cl_resptag  = resp_tag_q;
    // Response beats are always taken; beats arriving outside RD_DATA are dropped.
    assign bus_respack = bus_respcyc;

    a_resp_outside_rd: assert property (@(posedge clk) disable iff (reset)
        bus_respcyc |-> (state_q == RD_DATA));

endmodule

// File: tb/tb_mod_rr_arbiter.sv
`define CHK(t, o, e) chk(t, 512'(o), 512'(e))

module tb_mod_rr_arbiter;

    logic clk;
    logic reset;

    // instance A: 2 clients, 8 beats of 64 bits
    logic [1:0]    a_reqcyc;
    logic [127:0]  a_req;
    logic [25:0]   a_reqtag;
    logic [1023:0] a_reqdata;
    logic [1:0]    a_reqack, a_respcyc;
    logic [511:0]  a_resp;
    logic [12:0]   a_resptag;
    logic          a_bus_reqcyc, a_bus_reqack, a_bus_respcyc, a_bus_respack;
    logic [63:0]   a_bus_req, a_bus_resp;
    logic [12:0]   a_bus_reqtag, a_bus_resptag;

    // instance B: 4 clients, 4 beats of 128 bits
    logic [3:0]    b_reqcyc;
    logic [511:0]  b_req;
    logic [51:0]   b_reqtag;
    logic [2047:0] b_reqdata;
    logic [3:0]    b_reqack, b_respcyc;
    logic [511:0]  b_resp;
    logic [12:0]   b_resptag;
    logic          b_bus_reqcyc, b_bus_reqack, b_bus_respcyc, b_bus_respack;
    logic [127:0]  b_bus_req, b_bus_resp;
    logic [12:0]   b_bus_reqtag, b_bus_resptag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mod_rr_arbiter #(.NUM_CLIENTS(2), .LINE_WIDTH(512), .BEAT_WIDTH(64), .TAG_WIDTH(13)) dut_a (
        .clk(clk), .reset(reset),
        .cl_reqcyc(a_reqcyc), .cl_req(a_req), .cl_reqtag(a_reqtag), .cl_reqdata(a_reqdata),
        .cl_reqack(a_reqack), .cl_respcyc(a_respcyc), .cl_resp(a_resp), .cl_resptag(a_resptag),
        .bus_reqcyc(a_bus_reqcyc), .bus_req(a_bus_req), .bus_reqtag(a_bus_reqtag),
        .bus_reqack(a_bus_reqack), .bus_respcyc(a_bus_respcyc), .bus_resp(a_bus_resp),
        .bus_resptag(a_bus_resptag), .bus_respack(a_bus_respack)
    );

    mod_rr_arbiter #(.NUM_CLIENTS(4), .LINE_WIDTH(512), .BEAT_WIDTH(128), .TAG_WIDTH(13)) dut_b (
        .clk(clk), .reset(reset),
        .cl_reqcyc(b_reqcyc), .cl_req(b_req), .cl_reqtag(b_reqtag), .cl_reqdata(b_reqdata),
        .cl_reqack(b_reqack), .cl_respcyc(b_respcyc), .cl_resp(b_resp), .cl_resptag(b_resptag),
        .bus_reqcyc(b_bus_reqcyc), .bus_req(b_bus_req), .bus_reqtag(b_bus_reqtag),
        .bus_reqack(b_bus_reqack), .bus_respcyc(b_bus_respcyc), .bus_resp(b_bus_resp),
        .bus_resptag(b_bus_resptag), .bus_respack(b_bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            checks++;
            if ((a_reqack & (a_reqack - 2'd1)) != 2'd0) begin
                errors++;
                $error("FAIL a_reqack not one-hot observed=%0h", a_reqack);
            end
            if ((a_respcyc & (a_respcyc - 2'd1)) != 2'd0) begin
                errors++;
                $error("FAIL a_respcyc not one-hot observed=%0h", a_respcyc);
            end
            if ((b_reqack & (b_reqack - 4'd1)) != 4'd0) begin
                errors++;
                $error("FAIL b_reqack not one-hot observed=%0h", b_reqack);
            end
            if (a_bus_respack !== a_bus_respcyc) begin
                errors++;
                $error("FAIL bus_respack observed=%0b expected=%0b", a_bus_respack, a_bus_respcyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Full read on A; caller has already raised the request.
    task automatic a_read(input logic [1:0] g, input logic [63:0] addr, input logic [12:0] tag,
                          input logic [7:0] base, input logic [12:0] rtag);
        logic [511:0] exp_line;
        int t0;
        #1 `CHK("rd_gnt", a_reqack, g);
        t0 = cyc;
        tick();
        a_reqcyc = '0;
        #1 `CHK("rd_addr_cyc", a_bus_reqcyc, 1'b1);
        `CHK("rd_addr", a_bus_req, addr);
        `CHK("rd_addr_tag", a_bus_reqtag, tag);
        a_bus_reqack = 1'b1;
        tick();
        a_bus_reqack = 1'b0;
        #1 `CHK("rd_bus_quiet", a_bus_reqcyc, 1'b0);
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            a_bus_respcyc = 1'b1;
            a_bus_resp    = 64'(base) + 64'(k);
            a_bus_resptag = rtag + 13'(k);
            exp_line[k*64 +: 64] = 64'(base) + 64'(k);
            #1 `CHK("rd_respack", a_bus_respack, 1'b1);
            `CHK("rd_no_early_resp", a_respcyc, 2'b00);
            tick();
        end
        a_bus_respcyc = 1'b0;
        #1 `CHK("rd_respcyc", a_respcyc, g);
        `CHK("rd_line", a_resp, exp_line);
        `CHK("rd_resptag", a_resptag, rtag + 13'd7);
        `CHK("rd_latency", 32'(cyc - t0), 32'd10);
        tick();
        #1 `CHK("rd_resp_pulse", a_respcyc, 2'b00);
    endtask

    // Full write on A with a zero-wait bus; caller sets requests and line data.
    task automatic a_write(input logic [1:0] g, input logic [63:0] addr,
                           input logic [7:0] base, input logic [12:0] tag);
        int t0;
        #1 `CHK("wr_gnt", a_reqack, g);
        t0 = cyc;
        tick();
        #1 `CHK("wr_addr", a_bus_req, addr);
        `CHK("wr_addr_tag", a_bus_reqtag, tag);
        `CHK("busy_no_gnt", a_reqack, 2'b00);
        a_bus_reqack = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1 `CHK("wr_beat", a_bus_req, 64'(base) + 64'(k));
            tick();
        end
        a_bus_reqack = 1'b0;
        #1 `CHK("wr_respcyc", a_respcyc, g);
        `CHK("wr_resptag", a_resptag, tag);
        `CHK("wr_latency", 32'(cyc - t0), 32'd10);
        tick();
    endtask

    task automatic b_write(input logic [3:0] g, input logic [127:0] addr,
                           input logic [7:0] base, input logic [12:0] tag);
        int t0;
        #1 `CHK("b_gnt", b_reqack, g);
        t0 = cyc;
        tick();
        #1 `CHK("b_addr", b_bus_req, addr);
        `CHK("b_addr_tag", b_bus_reqtag, tag);
        b_bus_reqack = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1 `CHK("b_beat", b_bus_req, 128'(base) + 128'(k));
            tick();
        end
        b_bus_reqack = 1'b0;
        #1 `CHK("b_respcyc", b_respcyc, g);
        `CHK("b_latency", 32'(cyc - t0), 32'd6);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        a_reqcyc = '0; a_req = '0; a_reqtag = '0; a_reqdata = '0;
        a_bus_reqack = 1'b0; a_bus_respcyc = 1'b0; a_bus_resp = '0; a_bus_resptag = '0;
        b_reqcyc = '0; b_req = '0; b_reqtag = '0; b_reqdata = '0;
        b_bus_reqack = 1'b0; b_bus_respcyc = 1'b0; b_bus_resp = '0; b_bus_resptag = '0;
        tick();
        tick();
        a_reqcyc = 2'b11;
        #1 `CHK("rst_reqack", a_reqack, 2'b00);
        `CHK("rst_respcyc", a_respcyc, 2'b00);
        `CHK("rst_bus_reqcyc", a_bus_reqcyc, 1'b0);
        `CHK("rst_bus_req", a_bus_req, 64'h0);
        `CHK("rst_bus_reqtag", a_bus_reqtag, 13'h0);
        `CHK("rst_resp", a_resp, 512'h0);
        `CHK("rst_resptag", a_resptag, 13'h0);
        `CHK("rst_b_bus_reqcyc", b_bus_reqcyc, 1'b0);
        a_reqcyc = '0;
        reset = 1'b0;
        tick();

        // read, client 0, beats 0..7
        a_req[63:0] = 64'h1000;
        a_reqtag[12:0] = 13'h0001;
        a_reqcyc = 2'b01;
        a_read(2'b01, 64'h1000, 13'h0001, 8'h00, 13'h0100);

        // write, client 1, beats A0..A7
        a_req[127:64] = 64'h2000;
        a_reqtag[25:13] = 13'h0000;
        for (int k = 0; k < 8; k++) a_reqdata[512 + k*64 +: 64] = 64'h00A0 + 64'(k);
        a_reqcyc = 2'b10;
        a_write(2'b10, 64'h2000, 8'hA0, 13'h0000);
        a_reqcyc = '0;

        // write, client 0, bus stalls for 5 cycles on beat 2
        a_req[63:0] = 64'h3000;
        a_reqtag[12:0] = 13'h0002;
        for (int k = 0; k < 8; k++) a_reqdata[k*64 +: 64] = 64'h00B0 + 64'(k);
        a_reqcyc = 2'b01;
        #1 `CHK("stall_gnt", a_reqack, 2'b01);
        tick();
        a_reqcyc = '0;
        a_bus_reqack = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            #1 `CHK("stall_beat", a_bus_req, 64'h00B0 + 64'(k));
            tick();
        end
        a_bus_reqack = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1 `CHK("stall_hold", a_bus_req, 64'h00B2);
            `CHK("stall_cyc", a_bus_reqcyc, 1'b1);
            tick();
        end
        a_bus_reqack = 1'b1;
        for (int k = 2; k < 8; k++) begin
            #1 `CHK("stall_beat", a_bus_req, 64'h00B0 + 64'(k));
            tick();
        end
        a_bus_reqack = 1'b0;
        #1 `CHK("stall_respcyc", a_respcyc, 2'b01);
        tick();

        // read on client 1 abandoned by reset after 3 beats
        a_req[127:64] = 64'h4000;
        a_reqtag[25:13] = 13'h0003;
        a_reqcyc = 2'b10;
        #1 `CHK("abort_gnt", a_reqack, 2'b10);
        tick();
        a_reqcyc = '0;
        a_bus_reqack = 1'b1;
        tick();
        a_bus_reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_bus_respcyc = 1'b1;
            a_bus_resp = 64'hEE00 + 64'(k);
            a_bus_resptag = 13'h0077;
            tick();
        end
        a_bus_respcyc = 1'b0;
        reset = 1'b1;
        tick();
        #1 `CHK("abort_respcyc", a_respcyc, 2'b00);
        `CHK("abort_bus_reqcyc", a_bus_reqcyc, 1'b0);
        `CHK("abort_resp", a_resp, 512'h0);
        `CHK("abort_resptag", a_resptag, 13'h0);
        `CHK("abort_bus_req", a_bus_req, 64'h0);
        reset = 1'b0;
        tick();
        #1 `CHK("abort_quiet", a_respcyc, 2'b00);

        // pointer back to 0: client 0 read completes after the abort
        a_req[63:0] = 64'h5000;
        a_reqtag[12:0] = 13'h0005;
        a_reqcyc = 2'b01;
        a_read(2'b01, 64'h5000, 13'h0005, 8'h50, 13'h00A0);

        // both clients request every cycle: grants alternate 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_req = {64'h6000, 64'h5800};
        a_reqtag = '0;
        for (int k = 0; k < 8; k++) begin
            a_reqdata[k*64 +: 64]       = 64'h00C0 + 64'(k);
            a_reqdata[512 + k*64 +: 64] = 64'h00D0 + 64'(k);
        end
        a_reqcyc = 2'b11;
        a_write(2'b01, 64'h5800, 8'hC0, 13'h0000);
        a_write(2'b10, 64'h6000, 8'hD0, 13'h0000);
        a_write(2'b01, 64'h5800, 8'hC0, 13'h0000);
        a_write(2'b10, 64'h6000, 8'hD0, 13'h0000);
        a_reqcyc = '0;

        // four clients, 4-beat lines: grants 0,1,2,3 then wrap to 0
        for (int c = 0; c < 4; c++) begin
            b_req[c*128 +: 128] = 128'(256 * (c + 1));
            b_reqtag[c*13 +: 13] = 13'(16 + 2 * c);
            for (int k = 0; k < 4; k++)
                b_reqdata[c*512 + k*128 +: 128] = 128'(8'h80 + 16 * c + k);
        end
        b_reqcyc = 4'hF;
        b_write(4'b0001, 128'h100, 8'h80, 13'd16);
        b_write(4'b0010, 128'h200, 8'h90, 13'd18);
        b_write(4'b0100, 128'h300, 8'hA0, 13'd20);
        b_write(4'b1000, 128'h400, 8'hB0, 13'd22);
        b_write(4'b0001, 128'h100, 8'h80, 13'd16);
        b_reqcyc = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
